// File: rtl/hmem_arbiter.sv
// hmem_arbiter: shares one downstream hmem port between the I-cache (index 0) and the
// D-cache (index 1), holding each grant for a whole burst. Define HMEM_ARB_PERF_EN for perf counters.
package hmem_pkg;

    typedef enum logic {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } memory_operation_e;

    typedef enum logic [1:0] {
        MEM_SIZE_BYTE = 2'd0,
        MEM_SIZE_HALF = 2'd1,
        MEM_SIZE_WORD = 2'd2
    } memory_operation_size_e;

endpackage

module hmem_arbiter
    import hmem_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,

    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_lock,
    input  memory_operation_e      req_operation_0,
    input  memory_operation_e      req_operation_1,
    input  memory_operation_size_e req_size_0,
    input  memory_operation_size_e req_size_1,
    input  logic [XLEN-1:0]        req_address_0,
    input  logic [XLEN-1:0]        req_address_1,
    input  logic [XLEN-1:0]        req_store_word_1,
    output logic [1:0]             req_fulfilled,
    output logic [XLEN-1:0]        req_loaded_word,

    output logic                   mem_valid,
    output memory_operation_e      mem_operation,
    output memory_operation_size_e mem_size,
    output logic [XLEN-1:0]        mem_address,
    output logic [XLEN-1:0]        mem_store_word,
    input  logic                   mem_fulfilled,
    input  logic [XLEN-1:0]        mem_loaded_word,

    output logic                   grant_owner,
    output logic                   grant_active
`ifdef HMEM_ARB_PERF_EN
    ,
    output logic [XLEN-1:0]        perf_grant_count,
    output logic [XLEN-1:0]        perf_contention_cycles
`endif
);

    localparam int BEATS_W = $clog2(MAX_BURST + 1);
    localparam logic [BEATS_W-1:0] BEATS_LAST = BEATS_W'(MAX_BURST - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_owner_q, last_owner_d;
    logic [BEATS_W-1:0] beats_q, beats_d;

    logic owner_valid;
    logic owner_lock;
    logic other_valid;
    logic cap_hit;

    assign owner_valid = req_valid[owner_q];
    assign owner_lock  = req_lock[owner_q];
    assign other_valid = req_valid[~owner_q];
    // beats saturates at MAX_BURST-1 for a lone locked owner, so a late-arriving
    // competitor still forces a release on the very next beat.
    assign cap_hit     = (beats_q == BEATS_LAST);

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beats_d      = beats_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    state_d = ST_OWNED;
                    beats_d = '0;
                    owner_d = (&req_valid) ? ~last_owner_q : req_valid[1];
                end
            end

            ST_OWNED: begin
                if (mem_fulfilled) begin
                    if (!owner_lock || (cap_hit && other_valid)) begin
                        state_d      = ST_IDLE;
                        last_owner_d = owner_q;
                        beats_d      = '0;
                    end else if (!cap_hit) begin
                        beats_d = beats_q + 1'b1;
                    end
                end else if (!owner_valid && !owner_lock) begin
                    // Owner withdrew without a lock: give the port back.
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                    beats_d      = '0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the handshake outputs are masked by reset_n so a burst stops driving the
    // port in the very cycle reset is asserted, not one edge later.
    always_comb begin
        mem_valid      = 1'b0;
        req_fulfilled  = 2'b00;
        mem_operation  = MEM_LOAD;
        mem_size       = MEM_SIZE_WORD;
        mem_address    = '0;
        mem_store_word = '0;

        if (state_q == ST_OWNED) begin
            mem_operation  = owner_q ? req_operation_1 : req_operation_0;
            mem_size       = owner_q ? req_size_1      : req_size_0;
            mem_address    = owner_q ? req_address_1   : req_address_0;
            mem_store_word = owner_q ? req_store_word_1 : '0;
            if (reset_n) begin
                mem_valid              = owner_valid;
                req_fulfilled[owner_q] = mem_fulfilled;
            end
        end
    end

    assign req_loaded_word = mem_loaded_word;
    assign grant_active    = (state_q == ST_OWNED);
    assign grant_owner     = owner_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            beats_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beats_q      <= beats_d;
        end
    end

`ifdef HMEM_ARB_PERF_EN
    logic [XLEN-1:0] grant_count_q;
    logic [XLEN-1:0] contention_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant_count_q <= '0;
            contention_q  <= '0;
        end else begin
            if ((state_q == ST_IDLE) && (state_d == ST_OWNED) && (grant_count_q != '1)) begin
                grant_count_q <= grant_count_q + 1'b1;
            end
            if ((state_q == ST_OWNED) && other_valid && (contention_q != '1)) begin
                contention_q <= contention_q + 1'b1;
            end
        end
    end

    assign perf_grant_count       = grant_count_q;
    assign perf_contention_cycles = contention_q;
`endif

endmodule

// File: tb/tb_hmem_arbiter.sv
// Self-checking bench for hmem_arbiter: cycle vector table, directed burst/fairness/reset
// sequences, and a randomized run compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_hmem_arbiter;
    import hmem_pkg::*;

    localparam int XLEN        = 32;
    localparam int RAND_CYCLES = 3000;
    localparam int CAP4        = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset_n;
    logic [1:0]             req_valid, req_lock;
    memory_operation_e      req_operation_0, req_operation_1;
    memory_operation_size_e req_size_0, req_size_1;
    logic [XLEN-1:0]        req_address_0, req_address_1, req_store_word_1;
    logic                   mem_fulfilled;
    logic [XLEN-1:0]        mem_loaded_word;

    // Outputs of the MAX_BURST=8 (suffix 8) and MAX_BURST=4 (suffix 4) instances.
    logic [1:0]             rf8, rf4;
    logic [XLEN-1:0]        rlw8, rlw4, madr8, madr4, msw8, msw4;
    logic                   mv8, mv4, go8, go4, ga8, ga4;
    memory_operation_e      mop8, mop4;
    memory_operation_size_e msz8, msz4;
`ifdef HMEM_ARB_PERF_EN
    logic [XLEN-1:0]        pg8, pc8, pg4, pc4;
`endif

    hmem_arbiter #(.XLEN(XLEN), .MAX_BURST(8)) dut8 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_lock(req_lock),
        .req_operation_0(req_operation_0), .req_operation_1(req_operation_1),
        .req_size_0(req_size_0), .req_size_1(req_size_1),
        .req_address_0(req_address_0), .req_address_1(req_address_1),
        .req_store_word_1(req_store_word_1),
        .req_fulfilled(rf8), .req_loaded_word(rlw8),
        .mem_valid(mv8), .mem_operation(mop8), .mem_size(msz8),
        .mem_address(madr8), .mem_store_word(msw8),
        .mem_fulfilled(mem_fulfilled), .mem_loaded_word(mem_loaded_word),
        .grant_owner(go8), .grant_active(ga8)
`ifdef HMEM_ARB_PERF_EN
        , .perf_grant_count(pg8), .perf_contention_cycles(pc8)
`endif
    );

    hmem_arbiter #(.XLEN(XLEN), .MAX_BURST(CAP4)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_lock(req_lock),
        .req_operation_0(req_operation_0), .req_operation_1(req_operation_1),
        .req_size_0(req_size_0), .req_size_1(req_size_1),
        .req_address_0(req_address_0), .req_address_1(req_address_1),
        .req_store_word_1(req_store_word_1),
        .req_fulfilled(rf4), .req_loaded_word(rlw4),
        .mem_valid(mv4), .mem_operation(mop4), .mem_size(msz4),
        .mem_address(madr4), .mem_store_word(msw4),
        .mem_fulfilled(mem_fulfilled), .mem_loaded_word(mem_loaded_word),
        .grant_owner(go4), .grant_active(ga4)
`ifdef HMEM_ARB_PERF_EN
        , .perf_grant_count(pg4), .perf_contention_cycles(pc4)
`endif
    );

    // sel=0 observes the MAX_BURST=8 instance, sel=1 the MAX_BURST=4 instance.
    logic                   sel;
    logic [1:0]             cur_rf;
    logic [XLEN-1:0]        cur_rlw, cur_madr, cur_msw;
    logic                   cur_mv, cur_go, cur_ga;
    memory_operation_e      cur_mop;
    memory_operation_size_e cur_msz;

    always_comb begin
        if (sel) begin
            cur_rf = rf4; cur_rlw = rlw4; cur_madr = madr4; cur_msw = msw4;
            cur_mv = mv4; cur_go = go4; cur_ga = ga4; cur_mop = mop4; cur_msz = msz4;
        end else begin
            cur_rf = rf8; cur_rlw = rlw8; cur_madr = madr8; cur_msw = msw8;
            cur_mv = mv8; cur_go = go8; cur_ga = ga8; cur_mop = mop8; cur_msz = msz8;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        req_valid        = 2'b00;
        req_lock         = 2'b00;
        req_operation_0  = MEM_LOAD;
        req_operation_1  = MEM_LOAD;
        req_size_0       = MEM_SIZE_WORD;
        req_size_1       = MEM_SIZE_WORD;
        req_address_0    = '0;
        req_address_1    = '0;
        req_store_word_1 = '0;
        mem_fulfilled    = 1'b0;
        mem_loaded_word  = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic new_fields(input int i);
        if (i == 0) begin
            req_address_0   = $urandom;
            req_operation_0 = MEM_LOAD;
            req_size_0      = memory_operation_size_e'($urandom_range(0, 2));
        end else begin
            req_address_1    = $urandom;
            req_operation_1  = memory_operation_e'($urandom_range(0, 1));
            req_size_1       = memory_operation_size_e'($urandom_range(0, 2));
            req_store_word_1 = $urandom;
        end
    endtask

    // Cycle-by-cycle vectors on the MAX_BURST=4 instance, starting right after reset.
    typedef struct {
        logic [1:0] v;
        logic [1:0] l;
        logic       f;
        logic       mv;
        logic [1:0] rf;
        logic       ga;
        logic       go;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int rem[2];
        int m_own, m_last, m_beats, m_grants, m_cont, o;
        logic       exp_mv;
        logic [1:0] exp_rf;

        sel = 1'b1;
        reset_n = 1'b0;
        drive_idle();

        //             v      l     f     mv    rf     ga    go
        tbl[0]  = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}; // tie after reset
        tbl[1]  = '{2'b11, 2'b00, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0}; // I-cache wins, completes
        tbl[2]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0}; // bubble; stray fulfil ignored
        tbl[3]  = '{2'b11, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1}; // second tie goes to D-cache
        tbl[4]  = '{2'b11, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1};
        tbl[5]  = '{2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tbl[6]  = '{2'b01, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0};
        tbl[7]  = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0}; // abandoned request
        tbl[8]  = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tbl[9]  = '{2'b10, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tbl[10] = '{2'b00, 2'b10, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1}; // locked owner keeps grant
        tbl[11] = '{2'b10, 2'b10, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1};
        tbl[12] = '{2'b10, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1};
        tbl[13] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};

        // Reset state.
        do_reset();
        @(negedge clk);
        check("reset grant_active", cur_ga, 1'b0);
        check("reset grant_owner", cur_go, 1'b0);
        check("reset mem_valid", cur_mv, 1'b0);
        check("reset req_fulfilled", cur_rf, 2'b00);
`ifdef HMEM_ARB_PERF_EN
        check("reset perf_grant_count", pg4, 32'd0);
        check("reset perf_contention_cycles", pc4, 32'd0);
`endif

        // Vector table.
        do_reset();
        for (int k = 0; k < 14; k++) begin
            req_valid       = tbl[k].v;
            req_lock        = tbl[k].l;
            mem_fulfilled   = tbl[k].f;
            mem_loaded_word = 32'h1000_0000 + k;
            @(negedge clk);
            check($sformatf("vec%0d mem_valid", k), cur_mv, tbl[k].mv);
            check($sformatf("vec%0d req_fulfilled", k), cur_rf, tbl[k].rf);
            check($sformatf("vec%0d grant_active", k), cur_ga, tbl[k].ga);
            if (tbl[k].ga) check($sformatf("vec%0d grant_owner", k), cur_go, tbl[k].go);
            next_cycle();
        end

        // Single I-side read.
        sel = 1'b0;
        do_reset();
        req_valid = 2'b01;
        req_address_0 = 32'h0000_1000;
        @(negedge clk);
        check("iread arb cycle mem_valid", cur_mv, 1'b0);
        next_cycle();
        @(negedge clk);
        check("iread mem_valid", cur_mv, 1'b1);
        check("iread grant_owner", cur_go, 1'b0);
        check("iread mem_address", cur_madr, 32'h0000_1000);
        check("iread mem_operation", cur_mop, MEM_LOAD);
        check("iread mem_size", cur_msz, MEM_SIZE_WORD);
        check("iread mem_store_word", cur_msw, 32'h0);
        next_cycle();
        mem_fulfilled = 1'b1;
        mem_loaded_word = 32'hDEAD_BEEF;
        @(negedge clk);
        check("iread req_fulfilled", cur_rf, 2'b01);
        check("iread req_loaded_word", cur_rlw, 32'hDEAD_BEEF);
        next_cycle();
        req_valid = 2'b00;
        mem_fulfilled = 1'b0;
        @(negedge clk);
        check("iread bubble grant_active", cur_ga, 1'b0);
        check("iread bubble mem_valid", cur_mv, 1'b0);

        // D-side 8-beat writeback with the I-side waiting throughout.
        do_reset();
        req_valid = 2'b10;
        req_lock = 2'b10;
        req_operation_1 = MEM_STORE;
        @(negedge clk);
        next_cycle();
        for (int b = 1; b <= 8; b++) begin
            req_valid        = 2'b11;
            req_address_0    = 32'h0000_4000;
            req_lock         = (b < 8) ? 2'b10 : 2'b00;
            req_address_1    = 32'h0000_2000 + 4 * (b - 1);
            req_store_word_1 = 32'h5500_0000 + b;
            mem_fulfilled    = 1'b1;
            @(negedge clk);
            check($sformatf("wb beat%0d mem_valid", b), cur_mv, 1'b1);
            check($sformatf("wb beat%0d grant_owner", b), cur_go, 1'b1);
            check($sformatf("wb beat%0d req_fulfilled", b), cur_rf, 2'b10);
            check($sformatf("wb beat%0d mem_address", b), cur_madr, 32'h0000_2000 + 4 * (b - 1));
            check($sformatf("wb beat%0d mem_store_word", b), cur_msw, 32'h5500_0000 + b);
            check($sformatf("wb beat%0d mem_operation", b), cur_mop, MEM_STORE);
            next_cycle();
        end
        req_valid = 2'b01;
        req_lock = 2'b00;
        mem_fulfilled = 1'b0;
        @(negedge clk);
        check("wb bubble grant_active", cur_ga, 1'b0);
        check("wb bubble mem_valid", cur_mv, 1'b0);
        next_cycle();
        @(negedge clk);
        check("wb iside grant_active", cur_ga, 1'b1);
        check("wb iside grant_owner", cur_go, 1'b0);
        check("wb iside mem_valid", cur_mv, 1'b1);
        check("wb iside mem_address", cur_madr, 32'h0000_4000);
        check("wb iside mem_store_word", cur_msw, 32'h0);

        // Fairness cap on the MAX_BURST=4 instance.
        sel = 1'b1;
        do_reset();
        req_valid = 2'b10;
        req_lock = 2'b10;
        @(negedge clk);
        next_cycle();
        waited = 0;
        for (int b = 1; b <= CAP4; b++) begin
            req_valid = 2'b11;
            mem_fulfilled = 1'b1;
            @(negedge clk);
            check($sformatf("fair beat%0d grant_owner", b), cur_go, 1'b1);
            check($sformatf("fair beat%0d req_fulfilled", b), cur_rf, 2'b10);
            if (req_valid[0]) waited++;
            next_cycle();
        end
        mem_fulfilled = 1'b0;
        @(negedge clk);
        check("fair release grant_active", cur_ga, 1'b0);
        next_cycle();
        @(negedge clk);
        check("fair iside grant_active", cur_ga, 1'b1);
        check("fair iside grant_owner", cur_go, 1'b0);
        check("fair iside mem_valid", cur_mv, 1'b1);
`ifdef HMEM_ARB_PERF_EN
        check("fair perf_grant_count", pg4, 32'd2);
        check("fair perf_contention_cycles", pc4, waited);
`endif
        next_cycle();

        // Reset asserted on beat 3 of a locked burst.
        sel = 1'b0;
        do_reset();
        req_valid = 2'b10;
        req_lock = 2'b10;
        @(negedge clk);
        next_cycle();
        for (int b = 1; b <= 2; b++) begin
            mem_fulfilled = 1'b1;
            @(negedge clk);
            check($sformatf("rst beat%0d req_fulfilled", b), cur_rf, 2'b10);
            next_cycle();
        end
        reset_n = 1'b0;
        @(negedge clk);
        check("rst beat3 mem_valid", cur_mv, 1'b0);
        check("rst beat3 req_fulfilled", cur_rf, 2'b00);
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        check("rst after grant_active", cur_ga, 1'b0);
        check("rst after mem_valid", cur_mv, 1'b0);
        check("rst after req_fulfilled", cur_rf, 2'b00);
        next_cycle();
        mem_fulfilled = 1'b0;
        @(negedge clk);
        check("rst reissue grant_active", cur_ga, 1'b1);
        check("rst reissue grant_owner", cur_go, 1'b1);

        // Randomized traffic against the reference model (MAX_BURST=4 instance).
        sel = 1'b1;
        do_reset();
        rem[0] = 0;
        rem[1] = 0;
        m_own = -1;
        m_last = 1;
        m_beats = 0;
        m_grants = 0;
        m_cont = 0;
        for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (rem[i] == 0) begin
                    if ($urandom_range(0, 3) == 0) begin
                        rem[i] = $urandom_range(1, 6);
                        new_fields(i);
                    end
                end else if ($urandom_range(0, 59) == 0) begin
                    rem[i] = 0;
                end
            end
            req_valid = {rem[1] != 0, rem[0] != 0};
            req_lock  = {rem[1] > 1, rem[0] > 1};

            exp_mv = 1'b0;
            exp_rf = 2'b00;
            if (m_own >= 0) begin
                exp_mv = req_valid[m_own];
                mem_fulfilled = exp_mv && ($urandom_range(0, 2) == 0);
                if (mem_fulfilled) exp_rf[m_own] = 1'b1;
            end else begin
                mem_fulfilled = ($urandom_range(0, 7) == 0);
            end
            mem_loaded_word = $urandom;

            @(negedge clk);
            check("rnd mem_valid", cur_mv, exp_mv);
            check("rnd req_fulfilled", cur_rf, exp_rf);
            check("rnd req_loaded_word", cur_rlw, mem_loaded_word);
            check("rnd grant_active", cur_ga, m_own >= 0);
            if (m_own >= 0) begin
                check("rnd grant_owner", cur_go, m_own);
                check("rnd mem_address", cur_madr, (m_own == 1) ? req_address_1 : req_address_0);
                check("rnd mem_operation", cur_mop, (m_own == 1) ? req_operation_1 : req_operation_0);
                check("rnd mem_size", cur_msz, (m_own == 1) ? req_size_1 : req_size_0);
                check("rnd mem_store_word", cur_msw, (m_own == 1) ? req_store_word_1 : 32'h0);
            end

            if (m_own < 0) begin
                if (req_valid != 2'b00) begin
                    m_own = (req_valid == 2'b11) ? 1 - m_last : (req_valid[0] ? 0 : 1);
                    m_beats = 0;
                    m_grants++;
                end
            end else begin
                o = m_own;
                if (req_valid[1 - o]) m_cont++;
                if (mem_fulfilled) begin
                    m_beats++;
                    if (!req_lock[o] || (m_beats >= CAP4 && req_valid[1 - o])) begin
                        m_last = o;
                        m_own = -1;
                    end
                end else if (!req_valid[o] && !req_lock[o]) begin
                    m_last = o;
                    m_own = -1;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (exp_rf[i]) begin
                    rem[i]--;
                    if (rem[i] != 0) new_fields(i);
                end
            end
            next_cycle();
        end
`ifdef HMEM_ARB_PERF_EN
        check("rnd perf_grant_count", pg4, m_grants);
        check("rnd perf_contention_cycles", pc4, m_cont);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
